array_feed_sched: RTL and testbench

- Scheduler that drains rows_p input FIFOs (one per systolic-array row) into the array's west edge with diagonal skew: row r starts r cycles after row 0.
- Issues yumi to each FIFO, registers popped data toward the array, and produces a global array step enable.
- Stalls the whole wavefront whenever any row due to issue has an empty FIFO, so skew is never broken.
- Sits between the per-row fifo instances and the systolic array core.

---
 rtl/sa_pkg.sv | 11 +
 rtl/array_feed_sched_skew_window.sv | 25 ++
 rtl/array_feed_sched.sv | 100 ++++++++++
 tb/tb_array_feed_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and sizing helpers for the systolic array feed path
package sa_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} feed_state_e;

    // Step counter must reach len_max + rows - 2, the last skewed diagonal
    function automatic int step_cnt_w(input int len_max, input int rows);
        return $clog2(len_max + rows);
    endfunction

endpackage

// File: rtl/array_feed_sched_skew_window.sv
// rtl/array_feed_sched_skew_window.sv - per-row active mask for the skewed wavefront
module skew_window
    import sa_pkg::*;
#(
    parameter  int rows_p    = 4,
    parameter  int len_max_p = 64,
    localparam int len_w     = $clog2(len_max_p + 1),
    localparam int t_w       = step_cnt_w(len_max_p, rows_p)
) (
    input  logic [t_w-1:0]    t,
    input  logic [len_w-1:0]  len_r,
    output logic [rows_p-1:0] active
);

    typedef logic [t_w:0] ext_t;

    for (genvar r = 0; r < rows_p; r++) begin : g_row
        ext_t lo;
        ext_t hi;
        assign lo        = ext_t'(r);
        assign hi        = ext_t'(r) + ext_t'(len_r);
        assign active[r] = ({1'b0, t} >= lo) && ({1'b0, t} < hi);
    end

endmodule

// File: rtl/array_feed_sched.sv
// rtl/array_feed_sched.sv - drains per-row FIFOs into the array west edge with diagonal skew
module array_feed_sched
    import sa_pkg::*;
#(
    parameter  int rows_p    = 4,
    parameter  int width_p   = 8,
    parameter  int len_max_p = 64,
    localparam int len_w     = $clog2(len_max_p + 1),
    localparam int t_w       = step_cnt_w(len_max_p, rows_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [len_w-1:0]          len_i,
    output logic                      idle_o,
    output logic                      done_o,
    input  logic [rows_p-1:0]         fifo_valid_i,
    input  logic [rows_p*width_p-1:0] fifo_data_i,
    output logic [rows_p-1:0]         fifo_yumi_o,
    output logic [rows_p*width_p-1:0] arr_data_o,
    output logic [rows_p-1:0]         arr_valid_o,
    output logic                      arr_en_o
);

    typedef logic [t_w:0]   ext_t;
    typedef logic [len_w:0] len_x_t;

    feed_state_e               state;
    logic [t_w-1:0]            t;
    logic [len_w-1:0]          len_r;
    logic [rows_p-1:0]         active;
    logic                      adv;
    logic                      last_step;
    logic                      len_ok;
    logic [rows_p*width_p-1:0] masked_data;

    skew_window #(
        .rows_p    (rows_p),
        .len_max_p (len_max_p)
    ) u_skew (
        .t      (t),
        .len_r  (len_r),
        .active (active)
    );

    assign len_ok    = (len_i != '0) && (len_x_t'(len_i) <= len_x_t'(len_max_p));
    // Only rows inside the window gate the wavefront; idle rows may sit empty
    assign adv       = (state == RUN) && ((active & ~fifo_valid_i) == '0);
    assign last_step = ext_t'(t) == ext_t'(len_r) + ext_t'(rows_p - 2);

    always_comb begin
        masked_data = '0;
        for (int r = 0; r < rows_p; r++) begin
            if (active[r]) begin
                masked_data[r*width_p +: width_p] = fifo_data_i[r*width_p +: width_p];
            end
        end
    end

    assign fifo_yumi_o = {rows_p{adv}} & active;
    assign arr_en_o    = adv || (state == DONE);
    assign idle_o      = (state == IDLE);
    assign done_o      = (state == DONE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            t           <= '0;
            len_r       <= '0;
            arr_valid_o <= '0;
            arr_data_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i && len_ok) begin
                        len_r <= len_i;
                        t     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        arr_valid_o <= active;
                        arr_data_o  <= masked_data;
                        t           <= t + 1'b1;
                        if (last_step) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    arr_valid_o <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_feed_sched.sv
// tb/tb_array_feed_sched.sv - randomized bench for array_feed_sched against a wavefront model
module tb_array_feed_sched;

    localparam int rows_p    = 4;
    localparam int width_p   = 8;
    localparam int len_max_p = 64;
    localparam int len_w     = $clog2(len_max_p + 1);

    logic                      clk_i = 1'b0;
    logic                      reset_i;
    logic                      start_i;
    logic [len_w-1:0]          len_i;
    logic                      idle_o;
    logic                      done_o;
    logic [rows_p-1:0]         fifo_valid_i;
    logic [rows_p*width_p-1:0] fifo_data_i;
    logic [rows_p-1:0]         fifo_yumi_o;
    logic [rows_p*width_p-1:0] arr_data_o;
    logic [rows_p-1:0]         arr_valid_o;
    logic                      arr_en_o;

    always #5 clk_i = ~clk_i;

    array_feed_sched #(
        .rows_p    (rows_p),
        .width_p   (width_p),
        .len_max_p (len_max_p)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .idle_o       (idle_o),
        .done_o       (done_o),
        .fifo_valid_i (fifo_valid_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_yumi_o  (fifo_yumi_o),
        .arr_data_o   (arr_data_o),
        .arr_valid_o  (arr_valid_o),
        .arr_en_o     (arr_en_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO contents as the real FIFOs hold them, plus everything ever pushed per row
    logic [width_p-1:0] q[rows_p][$];
    logic [width_p-1:0] hist[rows_p][$];
    int base;
    int m_phase;
    int m_k;
    int m_len;
    logic [rows_p-1:0]         e_valid;
    logic [rows_p*width_p-1:0] e_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_idle"}, idle_o, 1'b1);
        check_eq({tag, "_done"}, done_o, 1'b0);
        check_eq({tag, "_yumi"}, fifo_yumi_o, '0);
        check_eq({tag, "_valid"}, arr_valid_o, '0);
        check_eq({tag, "_data"}, arr_data_o, '0);
        check_eq({tag, "_en"}, arr_en_o, 1'b0);
    endtask

    task automatic cycle(input logic st, input int ln, input logic [rows_p-1:0] av);
        logic [rows_p-1:0] vld;
        logic [rows_p-1:0] act;
        logic              adv;
        @(negedge clk_i);
        check_eq("idle", idle_o, m_phase == 0);
        check_eq("done", done_o, m_phase == 2);
        check_eq("arr_valid", arr_valid_o, e_valid);
        check_eq("arr_data", arr_data_o, e_data);
        start_i = st;
        len_i   = ln[len_w-1:0];
        for (int r = 0; r < rows_p; r++) begin
            vld[r] = av[r] && (q[r].size() > 0);
            fifo_data_i[r*width_p +: width_p] = (q[r].size() > 0) ? q[r][0] : width_p'($urandom);
        end
        fifo_valid_i = vld;
        #1;
        for (int r = 0; r < rows_p; r++) begin
            act[r] = (m_phase == 1) && (r <= m_k) && (m_k < r + m_len);
        end
        adv = (m_phase == 1) && ((act & ~vld) == '0);
        check_eq("yumi", fifo_yumi_o, adv ? act : '0);
        check_eq("arr_en", arr_en_o, adv || (m_phase == 2));
        @(posedge clk_i);
        for (int r = 0; r < rows_p; r++) begin
            if (fifo_yumi_o[r] && q[r].size() > 0) void'(q[r].pop_front());
        end
        case (m_phase)
            0: if (st && ln >= 1 && ln <= len_max_p) begin
                m_phase = 1;
                m_k     = 0;
                m_len   = ln;
            end
            1: if (adv) begin
                for (int r = 0; r < rows_p; r++) begin
                    e_valid[r] = act[r];
                    e_data[r*width_p +: width_p] = act[r] ? hist[r][base + m_k - r] : '0;
                end
                if (m_k == m_len + rows_p - 2) m_phase = 2;
                m_k++;
            end
            default: begin
                e_valid = '0;
                m_phase = 0;
                base    = base + m_len;
            end
        endcase
    endtask

    // mode 0: plain, 1: row2 late, 2: row3 late, 3: random gaps and starts, 4: start held during run
    task automatic run_job(input int len, input int mode);
        int c;
        logic st;
        logic [rows_p-1:0] av;
        logic [width_p-1:0] v;
        for (int r = 0; r < rows_p; r++) begin
            for (int i = 0; i < len; i++) begin
                v = (mode <= 2) ? width_p'(r * 16 + i) : width_p'($urandom);
                q[r].push_back(v);
                hist[r].push_back(v);
            end
        end
        c = 0;
        do begin
            st = (c == 0) || (mode == 3 && $urandom_range(0, 4) == 0) || (mode == 4 && m_phase == 1);
            av = '1;
            if (mode == 1 && c < 6) av[2] = 1'b0;
            if (mode == 2 && c < 4) av[3] = 1'b0;
            if (mode == 3) av = rows_p'($urandom) | rows_p'($urandom);
            cycle(st, (c == 0) ? len : int'($urandom_range(0, 127)), av);
            c++;
        end while (m_phase != 0 && c < 600);
        check_eq("job_ends", m_phase == 0, 1'b1);
    endtask

    initial begin
        int c;
        reset_i      = 1'b0;
        start_i      = 1'b0;
        len_i        = '0;
        fifo_valid_i = '0;
        fifo_data_i  = '0;
        base         = 0;
        m_phase      = 0;
        m_k          = 0;
        m_len        = 0;
        e_valid      = '0;
        e_data       = '0;
        #12;
        check_reset_outputs("por");
        @(negedge clk_i);
        reset_i = 1'b1;

        run_job(3, 0);
        run_job(3, 1);
        run_job(2, 2);

        cycle(1'b1, 0, '1);
        cycle(1'b1, 65, '1);
        cycle(1'b1, 127, '1);
        cycle(1'b0, 0, '1);
        run_job(4, 4);

        for (int j = 0; j < 20; j++) begin
            run_job(int'($urandom_range(1, 12)), 3);
            if ($urandom_range(0, 1) == 1) cycle(1'b0, 0, '1);
        end
        run_job(1, 3);
        run_job(len_max_p, 3);

        for (int r = 0; r < rows_p; r++) begin
            for (int i = 0; i < 8; i++) begin
                q[r].push_back(width_p'($urandom));
                hist[r].push_back(q[r][q[r].size() - 1]);
            end
        end
        c = 0;
        do begin
            cycle(c == 0, 8, '1);
            c++;
        end while (m_k < 3 && c < 50);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_phase = 0;
        e_valid = '0;
        e_data  = '0;
        base    = 0;
        for (int r = 0; r < rows_p; r++) begin
            q[r].delete();
            hist[r].delete();
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int r = 0; r < rows_p; r++) begin
            for (int i = 0; i < 4; i++) begin
                q[r].push_back(width_p'(i + 1));
                hist[r].push_back(width_p'(i + 1));
            end
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, '1);
        run_job(3, 3);
        cycle(1'b0, 0, '1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
